// File: rtl/fp_mul_core.sv
// fp_mul_core: sequential binary32 significand multiplier feeding the normalize
// stage. Classifies operands, forms sign and biased exponent sum, then runs a
// 24-step shift-add loop to build the exact 48-bit significand product.
module fp_mul_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_out,
  output logic [7:0]  exp_out,
  output logic [24:0] frac_out,
  output logic        sticky,
  output logic        zero,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [47:0]        mcand_q, mcand_d;
  logic [23:0]        mplier_q, mplier_d;
  logic [47:0]        acc_q, acc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic signed [9:0]  e_q, e_d;
  logic               sign_q, sign_d;
  logic [7:0]         exp_q, exp_d;
  logic [24:0]        frac_q, frac_d;
  logic               sticky_q, sticky_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic [7:0]         ea, eb;
  logic signed [9:0]  e_sum;
  logic [47:0]        acc_sum;

  assign ea = a[30:23];
  assign eb = b[30:23];
  // 10-bit signed width covers the full range -125 .. 381
  assign e_sum   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
  // Partial-product accumulate for the current multiplier LSB
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 48'd0);

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sign_out  = sign_q;
  assign exp_out   = exp_q;
  assign frac_out  = frac_q;
  assign sticky    = sticky_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

  // Next-state, datapath and result-register update
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    e_d      = e_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    frac_d   = frac_q;
    sticky_d = sticky_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d   = a[31] ^ b[31];
          e_d      = e_sum;
          mcand_d  = {24'd0, 1'b1, a[22:0]};
          mplier_d = {1'b1, b[22:0]};
          acc_d    = 48'd0;
          cnt_d    = 5'd0;
          exp_d    = 8'd0;
          frac_d   = 25'd0;
          sticky_d = 1'b0;
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          // Zero/denormal wins over Inf/NaN, so 0 x Inf reports zero
          if (ea == 8'd0 || eb == 8'd0) begin
            zero_d  = 1'b1;
            state_d = S_DONE;
          end else if (ea == 8'hFF || eb == 8'hFF) begin
            ovf_d   = 1'b1;
            exp_d   = 8'hFF;
            state_d = S_DONE;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = {mcand_q[46:0], 1'b0};
        mplier_d = {1'b0, mplier_q[23:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd23) begin
          state_d = S_DONE;
          if (e_q < 10'sd0) begin
            unf_d = 1'b1;
            zero_d = 1'b1;
          end else if (e_q > 10'sd254) begin
            ovf_d = 1'b1;
            exp_d = 8'hFF;
          end else begin
            exp_d    = e_q[7:0];
            frac_d   = acc_sum[47:23];
            sticky_d = |acc_sum[22:0];
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= 48'd0;
      mplier_q <= 24'd0;
      acc_q    <= 48'd0;
      cnt_q    <= 5'd0;
      e_q      <= 10'sd0;
      sign_q   <= 1'b0;
      exp_q    <= 8'd0;
      frac_q   <= 25'd0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      e_q      <= e_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      frac_q   <= frac_d;
      sticky_q <= sticky_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

endmodule
